segment_scan_ctrl: RTL and testbench
====================================

Name: segment_scan_ctrl

Overview:
- Scan controller for the multiplexed 4-digit 7-segment clock display.
- Accepts a packed time value through a valid/ready handshake: data_show[11:6] is the high field (hours), [5:0] the low field (minutes).
- Converts each 6-bit field to two BCD digits with a sequential divide-by-10 FSM.
- Generates the 8-phase digit scan: active digit phases interleaved with blank phases. New values are committed only at a frame boundary, so the display never tears.

Parameters:
PRESCALE, 1024, clocks per scan phase (legal range 1..65535)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
data_show  input  12  time value; [11:6] high field 0-63, [5:0] low field 0-63
data_valid  input  1  load request for data_show
data_ready  output  1  high when the controller can accept a new value
byte_status  output  3  current scan phase 0-7
bytee  output  4  one-hot digit enable, active-high; 0000 = blank
digit_bcd  output  4  BCD value for the enabled digit; 0 when blank
frame_done  output  1  one-cycle pulse when the phase wraps 7 -> 0

Behaviour:
- Reset is synchronous and active-high on clock. Reset values:
  - prescale counter 0, byte_status 0, FSM IDLE
  - shadow, pending and display digit registers all 0
  - data_ready 1, frame_done 0
  - bytee 0001, digit_bcd 0
- Prescaler: counts 0..PRESCALE-1. tick = (count == PRESCALE-1); count then wraps to 0. With PRESCALE=1, tick is high every cycle.
- Phase: byte_status increments on tick and wraps 7 -> 0. frame_done = tick && byte_status==7, registered, so it pulses in the first cycle of phase 0.
- Decode (combinational from registered state):
  - phase 0: bytee 0001, low ones
  - phase 2: bytee 0010, low tens
  - phase 4: bytee 0100, high ones
  - phase 6: bytee 1000, high tens
  - odd phases: bytee 0000, digit_bcd 0
- Conversion FSM, states IDLE, CONV, WAIT_FRAME:
  - IDLE: data_ready=1. On data_valid && data_ready, capture data_show into shadow remainders, clear tens counters, go to CONV.
  - CONV: data_ready=0. Each cycle, each field whose remainder is >= 10 subtracts 10 and increments its tens count. Both fields run in parallel. When both remainders are < 10, latch the pending digits and go to WAIT_FRAME. Maximum 7 cycles in CONV (value 63).
  - WAIT_FRAME: data_ready=0. On tick with byte_status==7, copy pending digits into the display registers and go to IDLE. Phase 0 of the new frame shows the new value.
- data_valid while data_ready=0 is ignored; there is no queueing. data_show is sampled only on acceptance.
- Values 60-63 are legal and displayed literally (63 -> 6,3).
- The display registers hold the old value until commit. Until the first commit after reset, the display shows 00:00.
- Reset asserted in any state or phase overrides everything and aborts any conversion in progress.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in phases 2 and 6, if the displayed tens digit is 0, bytee is forced to 0000 and digit_bcd to 0. Ones digits are never blanked.
- Undefined: tens digits of 0 are driven normally (bytee 0010 / 1000, digit_bcd 0).

Test Plan:
- PRESCALE=4, release reset -> byte_status 0, bytee 0001, digit_bcd 0, data_ready 1. byte_status advances every 4 cycles through 0..7. frame_done pulses once every 32 cycles.
- data_show={6'd12,6'd34}, data_valid 1 cycle -> data_ready 0 on the next cycle. After the next frame wrap: phases 0/2/4/6 give digit_bcd 4/3/2/1 with bytee 0001/0010/0100/1000. Odd phases give bytee 0000. data_ready returns to 1.
- data_show={6'd63,6'd63} -> CONV lasts <=7 cycles. Display digits 3,6,3,6 after commit.
- Load {6'd1,6'd2}, then pulse data_valid with {6'd9,6'd9} while busy -> second request ignored. Display 2,0,1,0; data_ready stays 0 until commit.
- Assert reset during CONV, and separately during phase 5 -> the next cycle shows all reset values: byte_status 0, bytee 0001, display 0000, data_ready 1.
- {6'd5,6'd7} with LEADING_ZERO_BLANK_EN -> phases 2 and 6 give bytee 0000. Without the macro -> phase 2 gives bytee 0010 with digit_bcd 0, and phase 6 gives bytee 1000 with digit_bcd 0.

Source files
------------

// File: rtl/segment_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with BCD conversion.
// Optional macro LEADING_ZERO_BLANK_EN blanks tens digits that are zero.
module segment_scan_ctrl #(
    parameter int PRESCALE = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] data_show,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [2:0]  byte_status,
    output logic [3:0]  bytee,
    output logic [3:0]  digit_bcd,
    output logic        frame_done
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        WAIT_FRAME
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pre_cnt;
    logic        tick;
    logic        wrap;
    logic [5:0]  rem_lo;
    logic [5:0]  rem_hi;
    logic [3:0]  tens_lo;
    logic [3:0]  tens_hi;
    logic        lo_big;
    logic        hi_big;
    logic [15:0] pend;
    logic [15:0] disp;

    assign tick   = (pre_cnt == PRE_MAX);
    assign wrap   = tick && (byte_status == 3'd7);
    assign lo_big = (rem_lo >= 6'd10);
    assign hi_big = (rem_hi >= 6'd10);

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt     <= '0;
            byte_status <= '0;
            frame_done  <= 1'b0;
        end else begin
            pre_cnt     <= tick ? 16'd0 : pre_cnt + 16'd1;
            byte_status <= tick ? byte_status + 3'd1 : byte_status;
            frame_done  <= wrap;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        data_ready = 1'b0;
        unique case (state)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (!lo_big && !hi_big) begin
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (wrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Both fields divide by repeated subtraction in lockstep.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_lo  <= '0;
            rem_hi  <= '0;
            tens_lo <= '0;
            tens_hi <= '0;
            pend    <= '0;
            disp    <= '0;
        end else begin
            if (state == IDLE && data_valid) begin
                rem_hi  <= data_show[11:6];
                rem_lo  <= data_show[5:0];
                tens_lo <= '0;
                tens_hi <= '0;
            end
            if (state == CONV) begin
                if (lo_big) begin
                    rem_lo  <= rem_lo - 6'd10;
                    tens_lo <= tens_lo + 4'd1;
                end
                if (hi_big) begin
                    rem_hi  <= rem_hi - 6'd10;
                    tens_hi <= tens_hi + 4'd1;
                end
                if (!lo_big && !hi_big) begin
                    pend <= {tens_hi, rem_hi[3:0], tens_lo, rem_lo[3:0]};
                end
            end
            if (state == WAIT_FRAME && wrap) begin
                disp <= pend;
            end
        end
    end

    always_comb begin
        bytee     = 4'b0000;
        digit_bcd = 4'd0;
        unique case (byte_status)
            3'd0: begin
                bytee     = 4'b0001;
                digit_bcd = disp[3:0];
            end
            3'd2: begin
                bytee     = 4'b0010;
                digit_bcd = disp[7:4];
`ifdef LEADING_ZERO_BLANK_EN
                if (disp[7:4] == 4'd0) begin
                    bytee = 4'b0000;
                end
`endif
            end
            3'd4: begin
                bytee     = 4'b0100;
                digit_bcd = disp[11:8];
            end
            3'd6: begin
                bytee     = 4'b1000;
                digit_bcd = disp[15:12];
`ifdef LEADING_ZERO_BLANK_EN
                if (disp[15:12] == 4'd0) begin
                    bytee = 4'b0000;
                end
`endif
            end
            default: begin
                bytee     = 4'b0000;
                digit_bcd = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Directed testbench for segment_scan_ctrl with PRESCALE=4.
module tb_segment_scan_ctrl;

    localparam int PS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] data_show = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [2:0]  byte_status;
    logic [3:0]  bytee;
    logic [3:0]  digit_bcd;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    logic [3:0] cap_be [8];
    logic [3:0] cap_dg [8];

    segment_scan_ctrl #(.PRESCALE(PS)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_show  (data_show),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .byte_status(byte_status),
        .bytee      (bytee),
        .digit_bcd  (digit_bcd),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] exp_digit(int p, logic [3:0] lo1,
                                             logic [3:0] lo10,
                                             logic [3:0] hi1,
                                             logic [3:0] hi10);
        case (p)
            0: return lo1;
            2: return lo10;
            4: return hi1;
            6: return hi10;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] exp_bytee(int p, logic [3:0] d);
        logic [3:0] b;
        case (p)
            0: b = 4'b0001;
            2: b = 4'b0010;
            4: b = 4'b0100;
            6: b = 4'b1000;
            default: b = 4'b0000;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((p == 2 || p == 6) && d == 4'd0) b = 4'b0000;
`else
        if (d == 4'hf) b = 4'b0000;
`endif
        return b;
    endfunction

    // Called at the first negedge of phase 0; ends at the next phase 0.
    task automatic capture_frame();
        for (int p = 0; p < 8; p++) begin
            cap_be[p] = bytee;
            cap_dg[p] = digit_bcd;
            repeat (PS) @(negedge clock);
        end
    endtask

    task automatic load(input logic [5:0] hi, input logic [5:0] lo);
        data_show  = {hi, lo};
        data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
    endtask

    task automatic wait_commit(output int cyc, output bit early);
        cyc   = 0;
        early = 1'b0;
        while (!(frame_done && data_ready) && cyc < 200) begin
            if (data_ready) early = 1'b1;
            @(negedge clock);
            cyc++;
        end
        if (!(frame_done && data_ready)) cyc = -1;
    endtask

    task automatic test_reset();
        logic [2:0] eb;
        logic       ef;
        checks++;
        if (byte_status !== 3'd0 || bytee !== 4'b0001 ||
            digit_bcd !== 4'd0 || data_ready !== 1'b1 ||
            frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: bs=%0d be=%b dg=%0d rdy=%b fd=%b expected 0 0001 0 1 0",
                     byte_status, bytee, digit_bcd, data_ready, frame_done);
        end
        for (int i = 0; i <= 64; i++) begin
            eb = 3'((i / PS) % 8);
            ef = (i == 32 || i == 64);
            checks++;
            if (byte_status !== eb || frame_done !== ef) begin
                failures++;
                $display("FAIL phase_seq cyc%0d: bs=%0d fd=%b expected bs=%0d fd=%b",
                         i, byte_status, frame_done, eb, ef);
            end
            if (i < 64) @(negedge clock);
        end
    endtask

    task automatic test_load_12_34();
        int cyc;
        bit early;
        logic [3:0] ed;
        load(6'd12, 6'd34);
        checks++;
        if (data_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_12_34: data_ready=%b expected 0", data_ready);
        end
        wait_commit(cyc, early);
        checks++;
        if (cyc < 0 || early) begin
            failures++;
            $display("FAIL commit_12_34: cycles=%0d early=%b expected commit, no early ready",
                     cyc, early);
        end
        capture_frame();
        for (int p = 0; p < 8; p++) begin
            ed = exp_digit(p, 4'd4, 4'd3, 4'd2, 4'd1);
            checks++;
            if (cap_be[p] !== exp_bytee(p, ed) || cap_dg[p] !== ed) begin
                failures++;
                $display("FAIL scan_12_34 ph%0d: be=%b dg=%0d expected be=%b dg=%0d",
                         p, cap_be[p], cap_dg[p], exp_bytee(p, ed), ed);
            end
        end
    endtask

    task automatic test_max_63();
        int cyc;
        bit early;
        logic [3:0] ed;
        load(6'd63, 6'd63);
        checks++;
        if (data_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_63: data_ready=%b expected 0", data_ready);
        end
        wait_commit(cyc, early);
        checks++;
        if (cyc < 1 || cyc > 32 || early) begin
            failures++;
            $display("FAIL commit_63: cycles=%0d early=%b expected commit at first wrap",
                     cyc, early);
        end
        capture_frame();
        for (int p = 0; p < 8; p++) begin
            ed = exp_digit(p, 4'd3, 4'd6, 4'd3, 4'd6);
            checks++;
            if (cap_be[p] !== exp_bytee(p, ed) || cap_dg[p] !== ed) begin
                failures++;
                $display("FAIL scan_63 ph%0d: be=%b dg=%0d expected be=%b dg=%0d",
                         p, cap_be[p], cap_dg[p], exp_bytee(p, ed), ed);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        bit early;
        logic [3:0] ed;
        load(6'd1, 6'd2);
        data_show  = {6'd9, 6'd9};
        data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
        checks++;
        if (data_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore: data_ready=%b expected 0", data_ready);
        end
        wait_commit(cyc, early);
        checks++;
        if (cyc < 0 || early) begin
            failures++;
            $display("FAIL commit_ignore: cycles=%0d early=%b expected commit, no early ready",
                     cyc, early);
        end
        capture_frame();
        for (int p = 0; p < 8; p++) begin
            ed = exp_digit(p, 4'd2, 4'd0, 4'd1, 4'd0);
            checks++;
            if (cap_be[p] !== exp_bytee(p, ed) || cap_dg[p] !== ed) begin
                failures++;
                $display("FAIL scan_ignore ph%0d: be=%b dg=%0d expected be=%b dg=%0d",
                         p, cap_be[p], cap_dg[p], exp_bytee(p, ed), ed);
            end
        end
    endtask

    task automatic test_reset_conv();
        logic [3:0] ed;
        load(6'd63, 6'd63);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (byte_status !== 3'd0 || bytee !== 4'b0001 ||
            digit_bcd !== 4'd0 || data_ready !== 1'b1 ||
            frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_conv: bs=%0d be=%b dg=%0d rdy=%b fd=%b expected 0 0001 0 1 0",
                     byte_status, bytee, digit_bcd, data_ready, frame_done);
        end
        capture_frame();
        for (int p = 0; p < 8; p++) begin
            ed = 4'd0;
            checks++;
            if (cap_be[p] !== exp_bytee(p, ed) || cap_dg[p] !== ed) begin
                failures++;
                $display("FAIL scan_after_reset ph%0d: be=%b dg=%0d expected be=%b dg=%0d",
                         p, cap_be[p], cap_dg[p], exp_bytee(p, ed), ed);
            end
        end
        checks++;
        if (data_ready !== 1'b1 || digit_bcd !== 4'd0) begin
            failures++;
            $display("FAIL aborted_conv: rdy=%b dg=%0d expected 1 0",
                     data_ready, digit_bcd);
        end
    endtask

    task automatic test_reset_phase5();
        int cyc;
        bit early;
        int n;
        load(6'd12, 6'd34);
        wait_commit(cyc, early);
        n = 0;
        while (byte_status !== 3'd5 && n < 64) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 64 || bytee !== 4'b0000 || digit_bcd !== 4'd0) begin
            failures++;
            $display("FAIL reach_ph5: waited=%0d be=%b dg=%0d expected <64 0000 0",
                     n, bytee, digit_bcd);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (byte_status !== 3'd0 || bytee !== 4'b0001 ||
            digit_bcd !== 4'd0 || data_ready !== 1'b1 ||
            frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ph5: bs=%0d be=%b dg=%0d rdy=%b fd=%b expected 0 0001 0 1 0",
                     byte_status, bytee, digit_bcd, data_ready, frame_done);
        end
        repeat (PS - 1) @(negedge clock);
        checks++;
        if (byte_status !== 3'd0) begin
            failures++;
            $display("FAIL prescale_restart_hold: bs=%0d expected 0", byte_status);
        end
        @(negedge clock);
        checks++;
        if (byte_status !== 3'd1) begin
            failures++;
            $display("FAIL prescale_restart_step: bs=%0d expected 1", byte_status);
        end
    endtask

    task automatic test_leading_zero();
        int cyc;
        bit early;
        logic [3:0] ed;
        load(6'd5, 6'd7);
        wait_commit(cyc, early);
        checks++;
        if (cyc < 0 || early) begin
            failures++;
            $display("FAIL commit_5_7: cycles=%0d early=%b expected commit, no early ready",
                     cyc, early);
        end
        capture_frame();
        for (int p = 0; p < 8; p++) begin
            ed = exp_digit(p, 4'd7, 4'd0, 4'd5, 4'd0);
            checks++;
            if (cap_be[p] !== exp_bytee(p, ed) || cap_dg[p] !== ed) begin
                failures++;
                $display("FAIL scan_5_7 ph%0d: be=%b dg=%0d expected be=%b dg=%0d",
                         p, cap_be[p], cap_dg[p], exp_bytee(p, ed), ed);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_load_12_34();
        test_max_63();
        test_busy_ignore();
        test_reset_conv();
        test_reset_phase5();
        test_leading_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
